// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// led_pattern_gen : NUM_LEDS channels of OFF / ON / BLINK / BREATHE drive from
//                   a shared tick prescaler and a shared PWM counter.
// Revision        : 1.0  initial release
// ============================================================================
module led_pattern_gen #(
   parameter int         CLK_HZ       = 100_000_000,
   parameter int         TICK_HZ      = 1000,
   parameter int         NUM_LEDS     = 4,
   parameter int         CNT_W        = 16,
   parameter int         PWM_W        = 8,
   parameter logic [1:0] RESET_MODE   = 2'b10,
   parameter int         RESET_PERIOD = 500,
   localparam int        CH_W         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic                CLK100MHZ,
   input  logic                CPU_RESETN,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [CNT_W-1:0]    cfg_period,
   output logic                tick,
   output logic [NUM_LEDS-1:0] LED
);

   localparam int              DIV          = CLK_HZ / TICK_HZ;
   localparam int              PS_W         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PS_W-1:0] PS_LAST      = PS_W'(DIV - 1);
   localparam logic [PWM_W-1:0] DUTY_MAX    = '1;
   localparam logic [1:0]      MODE_OFF     = 2'b00;
   localparam logic [1:0]      MODE_ON      = 2'b01;
   localparam logic [1:0]      MODE_BLINK   = 2'b10;
   localparam logic [1:0]      MODE_BREATHE = 2'b11;

   logic [PS_W-1:0]  presc;
   logic [PWM_W-1:0] pwm_cnt;

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         presc   <= '0;
         tick    <= 1'b0;
         pwm_cnt <= '0;
      end else begin
         tick    <= (presc == PS_LAST);
         presc   <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);
         pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      logic [1:0]       mode;
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] tick_cnt;
      logic [CNT_W-1:0] last_cnt;
      logic [PWM_W-1:0] duty;
      logic             blink_lvl;
      logic             dir;
      logic             led_q;
      logic             hit;
      logic             evt;

      // Channel indices >= NUM_LEDS never match, so such writes fall away here.
      assign hit      = cfg_we && (cfg_ch == CH_W'(i));
      assign last_cnt = (period == '0) ? '0 : period - CNT_W'(1);
      assign evt      = tick && (tick_cnt == last_cnt);

      always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
         if (!CPU_RESETN) begin
            mode      <= RESET_MODE;
            period    <= CNT_W'(RESET_PERIOD);
            tick_cnt  <= '0;
            blink_lvl <= 1'b0;
            duty      <= '0;
            dir       <= 1'b0;
            led_q     <= 1'b0;
         end else begin
            if (hit) begin
               mode      <= cfg_mode;
               period    <= cfg_period;
               tick_cnt  <= '0;
               blink_lvl <= 1'b0;
               duty      <= '0;
               dir       <= 1'b0;
            end else if (tick) begin
               if (evt) begin
                  tick_cnt <= '0;
                  if (mode == MODE_BLINK) begin
                     blink_lvl <= ~blink_lvl;
                  end
                  // Triangle ramp: reverse at either end instead of wrapping.
                  if (mode == MODE_BREATHE) begin
                     if (!dir) begin
                        if (duty == DUTY_MAX) begin
                           dir  <= 1'b1;
                           duty <= duty - PWM_W'(1);
                        end else begin
                           duty <= duty + PWM_W'(1);
                        end
                     end else begin
                        if (duty == '0) begin
                           dir  <= 1'b0;
                           duty <= PWM_W'(1);
                        end else begin
                           duty <= duty - PWM_W'(1);
                        end
                     end
                  end
               end else begin
                  tick_cnt <= tick_cnt + CNT_W'(1);
               end
            end

            case (mode)
               MODE_OFF:   led_q <= 1'b0;
               MODE_ON:    led_q <= 1'b1;
               MODE_BLINK: led_q <= blink_lvl;
               default:    led_q <= (pwm_cnt < duty);
            endcase
         end
      end

      assign LED[i] = led_q;
   end

endmodule
`default_nettype wire
